mem_access_unit: RTL and testbench

Parametrised data-memory access unit sitting between the execute stage of the pipelined core and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It is the successor to the core's current single-cycle, acknowledge-ignoring load/store path, and generalises it to XLEN of 32 or 64. It adds a proper ACKD_n wait-state handshake with pipeline stall, byte-lane alignment with sign/zero extension, misalignment detection, and a bus-timeout fault.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: moves execute-stage loads/stores onto the external data bus.
// Handles ACKD_n wait states with a stall, lane alignment/extension, misalignment and bus timeout.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_func,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            stall,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [4:0]      rsp_rd,
    output logic            fault,
    output logic [1:0]      fault_cause,
    output logic [XLEN-1:0] DAD,
    output logic            MREQ,
    output logic            WRITE,
    output logic [1:0]      SIZE,
    inout  wire  [XLEN-1:0] DDT,
    input  logic            ACKD_n
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_e;

    state_e            state;
    logic [2:0]        func_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   wdata_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  cnt;

    logic              misaligned;
    logic [XLEN-1:0]   wdata_rep;
    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   load_ext;

    // Illegal funct3 codes are reported the same way as misaligned addresses.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (req_func)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = req_addr[0];
            3'b010:         misaligned = |req_addr[1:0];
            3'b110:         misaligned = (XLEN != 64) || (|req_addr[1:0]);
            3'b011:         misaligned = (XLEN != 64) || (|req_addr[2:0]);
            default:        misaligned = 1'b1;
        endcase
    end

    always_comb begin
        wdata_rep = req_wdata;
        case (req_func[1:0])
            2'b00:   wdata_rep = {(XLEN / 8){req_wdata[7:0]}};
            2'b01:   wdata_rep = {(XLEN / 16){req_wdata[15:0]}};
            2'b10:   wdata_rep = {(XLEN / 32){req_wdata[31:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend per funct3.
    assign lane = DDT >> {off_q, 3'b000};

    always_comb begin
        load_ext = lane;
        case (func_q)
            3'b000:  load_ext = XLEN'($signed(lane[7:0]));
            3'b001:  load_ext = XLEN'($signed(lane[15:0]));
            3'b010:  load_ext = XLEN'($signed(lane[31:0]));
            3'b100:  load_ext = XLEN'(lane[7:0]);
            3'b101:  load_ext = XLEN'(lane[15:0]);
            3'b110:  load_ext = XLEN'(lane[31:0]);
            default: load_ext = lane;
        endcase
    end

    assign stall = ((state == IDLE) && req_valid) || (state == ACCESS);
    assign DDT   = ((state == ACCESS) && WRITE) ? wdata_q : 'z;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            func_q      <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_rd      <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            DAD         <= '0;
            MREQ        <= 1'b0;
            WRITE       <= 1'b0;
            SIZE        <= 2'b00;
        end else begin
            rsp_valid   <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            state   <= ACCESS;
                            MREQ    <= 1'b1;
                            WRITE   <= req_write;
                            SIZE    <= req_func[1:0];
                            DAD     <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            off_q   <= req_addr[OFF_W-1:0];
                            func_q  <= req_func;
                            wdata_q <= wdata_rep;
                            rd_q    <= req_rd;
                            cnt     <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // An acknowledge in the final allowed cycle beats the timeout.
                    if (!ACKD_n) begin
                        state <= DONE;
                        MREQ  <= 1'b0;
                        WRITE <= 1'b0;
                        if (!WRITE) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_ext;
                            rsp_rd    <= rd_q;
                        end
                    end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
                        state       <= FAULT;
                        MREQ        <= 1'b0;
                        WRITE       <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= 2'b10;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors on an XLEN=32/TIMEOUT=4 and an XLEN=64 instance.
// Stimulus pushes expected bus/response/fault events; a negedge monitor pops and compares them.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid32, req_valid64, req_write;
    logic [2:0]  req_func;
    logic [63:0] req_addr, req_wdata, tb_ddt;
    logic [4:0]  req_rd;
    logic        ACKD_n, tb_drv, sel64;

    logic        stall32, rsp_valid32, fault32, mreq32, write32;
    logic [31:0] rsp_rdata32, dad32;
    logic [4:0]  rsp_rd32;
    logic [1:0]  cause32, size32;
    wire  [31:0] ddt32;

    logic        stall64, rsp_valid64, fault64, mreq64, write64;
    logic [63:0] rsp_rdata64, dad64;
    logic [4:0]  rsp_rd64;
    logic [1:0]  cause64, size64;
    wire  [63:0] ddt64;

    assign ddt32 = (tb_drv && !sel64) ? tb_ddt[31:0] : 'z;
    assign ddt64 = (tb_drv && sel64) ? tb_ddt : 'z;

    mem_access_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(req_valid32), .req_write(req_write),
        .req_func(req_func), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .req_rd(req_rd), .stall(stall32), .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32),
        .rsp_rd(rsp_rd32), .fault(fault32), .fault_cause(cause32), .DAD(dad32),
        .MREQ(mreq32), .WRITE(write32), .SIZE(size32), .DDT(ddt32), .ACKD_n(ACKD_n)
    );

    mem_access_unit #(.XLEN(64), .TIMEOUT(15)) u64 (
        .clk(clk), .rst(rst), .req_valid(req_valid64), .req_write(req_write),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .stall(stall64), .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64),
        .rsp_rd(rsp_rd64), .fault(fault64), .fault_cause(cause64), .DAD(dad64),
        .MREQ(mreq64), .WRITE(write64), .SIZE(size64), .DDT(ddt64), .ACKD_n(ACKD_n)
    );

    logic        m_stall, m_rsp, m_fault, m_mreq, m_write;
    logic [63:0] m_rdata, m_dad, m_ddt;
    logic [4:0]  m_rd;
    logic [1:0]  m_cause, m_size;

    always_comb begin
        m_stall = stall32;  m_rsp = rsp_valid32; m_fault = fault32; m_mreq = mreq32;
        m_write = write32;  m_rdata = 64'(rsp_rdata32); m_dad = 64'(dad32);
        m_ddt = 64'(ddt32); m_rd = rsp_rd32; m_cause = cause32; m_size = size32;
        if (sel64) begin
            m_stall = stall64;  m_rsp = rsp_valid64; m_fault = fault64; m_mreq = mreq64;
            m_write = write64;  m_rdata = rsp_rdata64; m_dad = dad64;
            m_ddt = ddt64; m_rd = rsp_rd64; m_cause = cause64; m_size = size64;
        end
    end

    typedef enum {EV_BUS, EV_RSP, EV_FLT} ev_e;
    typedef struct {
        ev_e         kind;
        int          lat;
        logic [63:0] addr;
        logic        wr;
        logic [1:0]  code;
        logic [63:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   c0 = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_bus(input logic [63:0] addr, input logic wr, input logic [1:0] size,
                           input logic [63:0] data);
        exp_t e;
        e.kind = EV_BUS; e.lat = 1; e.addr = addr; e.wr = wr; e.code = size; e.data = data; e.rd = '0;
        sb.push_back(e);
    endtask

    task automatic exp_rsp(input int lat, input logic [63:0] data, input logic [4:0] rd);
        exp_t e;
        e.kind = EV_RSP; e.lat = lat; e.addr = '0; e.wr = 1'b0; e.code = '0; e.data = data; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic exp_flt(input int lat, input logic [1:0] cause);
        exp_t e;
        e.kind = EV_FLT; e.lat = lat; e.addr = '0; e.wr = 1'b0; e.code = cause; e.data = '0; e.rd = '0;
        sb.push_back(e);
    endtask

    task automatic consume(input ev_e k);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected event: got %s, expected nothing (t=%0t)", k.name(), $time);
            return;
        end
        e = sb.pop_front();
        check("event kind", 64'(k), 64'(e.kind));
        check("event cycle", 64'(cyc - c0), 64'(e.lat));
        case (k)
            EV_BUS: begin
                check("bus DAD", m_dad, e.addr);
                check("bus WRITE", 64'(m_write), 64'(e.wr));
                check("bus SIZE", 64'(m_size), 64'(e.code));
                if (e.wr) check("bus DDT store data", m_ddt, e.data);
            end
            EV_RSP: begin
                check("rsp_rdata", m_rdata, e.data);
                check("rsp_rd", 64'(m_rd), 64'(e.rd));
            end
            default: begin
                check("fault_cause", 64'(m_cause), 64'(e.code));
                check("MREQ at fault", 64'(m_mreq), 64'd0);
            end
        endcase
    endtask

    logic prev_mreq = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_mreq = 1'b0;
        end else begin
            if (m_mreq && !prev_mreq) consume(EV_BUS);
            if (m_rsp) consume(EV_RSP);
            if (m_fault) consume(EV_FLT);
            prev_mreq = m_mreq;
        end
    end

    // ack_at: cycle index (request cycle = 0) in which ACKD_n is driven low; -1 never.
    task automatic run_txn(input string name, input logic use64, input logic wr,
                           input logic [2:0] f, input logic [63:0] a, input logic [63:0] wd,
                           input logic [4:0] rd, input logic [63:0] bus, input int ack_at,
                           input int exp_stalls);
        int stalls = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        sel64 = use64; c0 = cyc;
        req_write = wr; req_func = f; req_addr = a; req_wdata = wd; req_rd = rd;
        tb_ddt = bus; tb_drv = !wr; ACKD_n = 1'b1;
        if (use64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (m_stall) stalls++; else done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
                ACKD_n = (ack_at == k + 1) ? 1'b0 : 1'b1;
            end
        end
        check({name, " completes within bound"}, 64'(done), 64'd1);
        check({name, " stall cycles"}, 64'(stalls), 64'(exp_stalls));
        @(posedge clk); #1;
        req_valid32 = 1'b0; req_valid64 = 1'b0; tb_drv = 1'b0; ACKD_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid32 = 1'b0; req_valid64 = 1'b0; req_write = 1'b0; req_func = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; tb_ddt = '0; tb_drv = 1'b0;
        ACKD_n = 1'b1; sel64 = 1'b0;
        #12;
        check("reset stall", 64'(m_stall), 64'd0);
        check("reset rsp_valid", 64'(m_rsp), 64'd0);
        check("reset fault", 64'(m_fault), 64'd0);
        check("reset MREQ", 64'(m_mreq), 64'd0);
        check("reset WRITE", 64'(m_write), 64'd0);
        check("reset fault_cause", 64'(m_cause), 64'd0);
        check("reset SIZE", 64'(m_size), 64'd0);
        check("reset DAD", m_dad, 64'd0);
        check("reset rsp_rdata", m_rdata, 64'd0);
        check("reset rsp_rd", 64'(m_rd), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // XLEN=32, TIMEOUT=4
        exp_bus(64'h100, 1'b0, 2'b10, '0); exp_rsp(2, 64'hDEADBEEF, 5'd1);
        run_txn("LW 0x100", 1'b0, 1'b0, 3'b010, 64'h100, '0, 5'd1, 64'hDEADBEEF, 1, 2);
        exp_bus(64'h100, 1'b0, 2'b00, '0); exp_rsp(2, 64'hFFFFFF80, 5'd2);
        run_txn("LB 0x103", 1'b0, 1'b0, 3'b000, 64'h103, '0, 5'd2, 64'h80123456, 1, 2);
        exp_bus(64'h100, 1'b0, 2'b00, '0); exp_rsp(2, 64'h00000080, 5'd3);
        run_txn("LBU 0x103", 1'b0, 1'b0, 3'b100, 64'h103, '0, 5'd3, 64'h80123456, 1, 2);
        exp_bus(64'h100, 1'b0, 2'b01, '0); exp_rsp(2, 64'h00008012, 5'd4);
        run_txn("LHU 0x102", 1'b0, 1'b0, 3'b101, 64'h102, '0, 5'd4, 64'h80123456, 1, 2);
        exp_bus(64'h100, 1'b0, 2'b01, '0); exp_rsp(2, 64'hFFFF8012, 5'd5);
        run_txn("LH 0x102", 1'b0, 1'b0, 3'b001, 64'h102, '0, 5'd5, 64'h80123456, 1, 2);
        exp_bus(64'h200, 1'b1, 2'b00, 64'hA5A5A5A5);
        run_txn("SB 0x201", 1'b0, 1'b1, 3'b000, 64'h201, 64'hA5, 5'd0, '0, 1, 2);
        check("rsp_rdata held after store", m_rdata, 64'hFFFF8012);
        check("rsp_rd held after store", 64'(m_rd), 64'd5);
        exp_bus(64'h204, 1'b1, 2'b01, 64'hBEEFBEEF);
        run_txn("SH 0x206 one wait", 1'b0, 1'b1, 3'b001, 64'h206, 64'h1234BEEF, 5'd0, '0, 2, 3);
        exp_bus(64'h104, 1'b0, 2'b10, '0); exp_rsp(5, 64'h12345678, 5'd6);
        run_txn("LW ack in last cycle", 1'b0, 1'b0, 3'b010, 64'h104, '0, 5'd6, 64'h12345678, 4, 5);
        exp_bus(64'h108, 1'b0, 2'b10, '0); exp_flt(5, 2'b10);
        run_txn("LW timeout", 1'b0, 1'b0, 3'b010, 64'h108, '0, 5'd7, 64'h0, -1, 5);
        exp_flt(1, 2'b01);
        run_txn("LH misaligned", 1'b0, 1'b0, 3'b001, 64'h101, '0, 5'd8, '0, 1, 1);
        exp_flt(1, 2'b01);
        run_txn("LD illegal at 32", 1'b0, 1'b0, 3'b011, 64'h100, '0, 5'd8, '0, 1, 1);
        exp_flt(1, 2'b01);
        run_txn("func 111 illegal", 1'b0, 1'b1, 3'b111, 64'h100, '0, 5'd8, '0, 1, 1);

        // Reset in the middle of an ACCESS: bus released at once, no response or fault afterwards.
        @(posedge clk); #1;
        sel64 = 1'b0; c0 = cyc; req_write = 1'b0; req_func = 3'b010; req_addr = 64'h100;
        req_rd = 5'd9; tb_ddt = 64'h55555555; tb_drv = 1'b1; req_valid32 = 1'b1;
        @(posedge clk); #1;
        req_valid32 = 1'b0;
        #2 rst = 1'b1; ACKD_n = 1'b0;
        #1;
        check("abort MREQ released", 64'(m_mreq), 64'd0);
        check("abort stall released", 64'(m_stall), 64'd0);
        @(posedge clk); #1 rst = 1'b0; ACKD_n = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
        exp_bus(64'h100, 1'b0, 2'b10, '0); exp_rsp(2, 64'hCAFEF00D, 5'd9);
        run_txn("LW after abort", 1'b0, 1'b0, 3'b010, 64'h100, '0, 5'd9, 64'hCAFEF00D, 1, 2);

        // XLEN=64, TIMEOUT=15
        exp_bus(64'h8, 1'b1, 2'b10, 64'h11223344_11223344);
        run_txn("SW64 0x8", 1'b1, 1'b1, 3'b010, 64'h8, 64'hFFFFFFFF_11223344, 5'd0, '0, 1, 2);
        exp_bus(64'h10, 1'b0, 2'b11, '0); exp_rsp(2, 64'h01234567_89ABCDEF, 5'd10);
        run_txn("LD64 0x10", 1'b1, 1'b0, 3'b011, 64'h10, '0, 5'd10, 64'h01234567_89ABCDEF, 1, 2);
        exp_bus(64'h10, 1'b0, 2'b10, '0); exp_rsp(2, 64'hFFFFFFFF_F0000001, 5'd11);
        run_txn("LW64 0x14", 1'b1, 1'b0, 3'b010, 64'h14, '0, 5'd11, 64'hF0000001_00000000, 1, 2);
        exp_bus(64'h10, 1'b0, 2'b10, '0); exp_rsp(2, 64'h00000000_F0000001, 5'd12);
        run_txn("LWU64 0x14", 1'b1, 1'b0, 3'b110, 64'h14, '0, 5'd12, 64'hF0000001_00000000, 1, 2);
        exp_flt(1, 2'b01);
        run_txn("LD64 misaligned", 1'b1, 1'b0, 3'b011, 64'h14, '0, 5'd13, '0, 1, 1);

        repeat (4) @(posedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
